// File: rtl/bios_loader_ctrl.sv
// UART program-download sequencer for the BIOS RAM: parses MAGIC/LEN/data/CSUM
// frames and emits one RAM write per 16-bit word, then releases the RAM via pg_done.
module bios_loader_ctrl #(
    parameter logic [15:0] ADDR_BASE   = 16'h0000,
    parameter logic [7:0]  MAGIC       = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 10_000_000
) (
    input  logic        pg_clk_i,
    input  logic        pg_rst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_ferr_i,
    output logic        pg_wen,
    output logic [15:0] pg_adr,
    output logic [15:0] pg_din,
    output logic        pg_done,
    output logic        pg_err,
    output logic        pg_busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DAT_LO, ST_DAT_HI, ST_CSUM, ST_DONE, ST_ERR
    } state_t;

    localparam logic [23:0] TIMER_LAST = 24'(TIMEOUT_CYC - 1);

    state_t      state_reg, state_next;
    logic [15:0] len_reg;
    logic [15:0] widx_reg;
    logic [7:0]  lo_reg;
    logic [7:0]  csum_reg;
    logic [23:0] timer_reg;
    logic        wen_reg;
    logic [15:0] adr_reg;
    logic [15:0] din_reg;

    // A byte flagged with a framing error is never used as data.
    logic        byte_ok;
    logic        timeout;
    logic [16:0] widx_plus1;
    logic [15:0] len_full;

    assign byte_ok    = rx_valid_i && !rx_ferr_i;
    assign timeout    = pg_busy && !rx_valid_i && (timer_reg == TIMER_LAST);
    assign widx_plus1 = {1'b0, widx_reg} + 17'd1;
    assign len_full   = {rx_data_i, len_reg[7:0]};

    always_ff @(posedge pg_clk_i or negedge pg_rst_n_i) begin
        if (!pg_rst_n_i) state_reg <= ST_IDLE;
        else             state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (pg_busy && (rx_ferr_i || timeout)) begin
            state_next = ST_ERR;
        end else if (byte_ok) begin
            case (state_reg)
                ST_IDLE, ST_ERR: if (rx_data_i == MAGIC) state_next = ST_LEN_LO;
                ST_LEN_LO:       state_next = ST_LEN_HI;
                ST_LEN_HI:       state_next = (len_full != 16'd0) ? ST_DAT_LO : ST_CSUM;
                ST_DAT_LO:       state_next = ST_DAT_HI;
                ST_DAT_HI:       state_next = (widx_plus1 < {1'b0, len_reg}) ? ST_DAT_LO : ST_CSUM;
                ST_CSUM:         state_next = (rx_data_i == csum_reg) ? ST_DONE : ST_ERR;
                default:         state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        pg_busy = 1'b1;
        pg_done = 1'b0;
        pg_err  = 1'b0;
        case (state_reg)
            ST_IDLE: pg_busy = 1'b0;
            ST_DONE: begin pg_busy = 1'b0; pg_done = 1'b1; end
            ST_ERR:  begin pg_busy = 1'b0; pg_err  = 1'b1; end
            default: pg_busy = 1'b1;
        endcase
    end

    // Datapath: the write is registered so it lands exactly one cycle after the high byte.
    always_ff @(posedge pg_clk_i or negedge pg_rst_n_i) begin
        if (!pg_rst_n_i) begin
            len_reg   <= '0;
            widx_reg  <= '0;
            lo_reg    <= '0;
            csum_reg  <= '0;
            timer_reg <= '0;
            wen_reg   <= 1'b0;
            adr_reg   <= '0;
            din_reg   <= '0;
        end else begin
            wen_reg <= 1'b0;
            if (rx_valid_i || (state_next != state_reg) || !pg_busy) timer_reg <= '0;
            else                                                     timer_reg <= timer_reg + 24'd1;
            if (byte_ok && !(pg_busy && rx_ferr_i)) begin
                case (state_reg)
                    ST_IDLE, ST_ERR: begin
                        if (rx_data_i == MAGIC) begin
                            widx_reg <= '0;
                            csum_reg <= '0;
                        end
                    end
                    ST_LEN_LO: len_reg[7:0]  <= rx_data_i;
                    ST_LEN_HI: len_reg[15:8] <= rx_data_i;
                    ST_DAT_LO: begin
                        lo_reg   <= rx_data_i;
                        csum_reg <= csum_reg + rx_data_i;
                    end
                    ST_DAT_HI: begin
                        csum_reg <= csum_reg + rx_data_i;
                        widx_reg <= widx_reg + 16'd1;
                        wen_reg  <= 1'b1;
                        adr_reg  <= ADDR_BASE + widx_reg;
                        din_reg  <= {rx_data_i, lo_reg};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pg_wen = wen_reg;
    assign pg_adr = adr_reg;
    assign pg_din = din_reg;

endmodule

// File: tb/tb_bios_loader_ctrl.sv
// Self-checking bench for bios_loader_ctrl: table vectors, hand-written corner
// sequences and random frames checked against a frame-level reference model.
module tb_bios_loader_ctrl;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ferr = 1'b0;

    logic        a_wen, a_done, a_err, a_busy;
    logic [15:0] a_adr, a_din;
    logic        b_wen, b_done, b_err, b_busy;
    logic [15:0] b_adr, b_din;

    always #5 clk = ~clk;

    bios_loader_ctrl #(.ADDR_BASE(16'h0000), .MAGIC(8'hA5), .TIMEOUT_CYC(TO)) dut_a (
        .pg_clk_i(clk), .pg_rst_n_i(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ferr_i(rx_ferr), .pg_wen(a_wen), .pg_adr(a_adr), .pg_din(a_din),
        .pg_done(a_done), .pg_err(a_err), .pg_busy(a_busy));

    bios_loader_ctrl #(.ADDR_BASE(16'hFFFF), .MAGIC(8'hA5), .TIMEOUT_CYC(TO)) dut_b (
        .pg_clk_i(clk), .pg_rst_n_i(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ferr_i(rx_ferr), .pg_wen(b_wen), .pg_adr(b_adr), .pg_din(b_din),
        .pg_done(b_done), .pg_err(b_err), .pg_busy(b_busy));

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
    logic [7:0]  tx_q[$];
    bit          both_seen = 1'b0;

    typedef struct {
        bit          rst;
        int          n;
        logic [7:0]  b [0:9];
        int          nwr;
        logic [15:0] adr_last;
        logic [15:0] din_last;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vt [0:3];

    always @(negedge clk) begin
        if (a_wen) got_a.push_back({a_adr, a_din});
        if (b_wen) got_b.push_back({b_adr, b_din});
        if ((a_done && a_err) || (b_done && b_err)) both_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_q(input int maxgap);
        foreach (tx_q[i]) send_byte(tx_q[i], $urandom_range(0, maxgap));
        tx_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_a", {a_wen, a_done, a_err, a_busy, a_adr, a_din}, 0);
        check("rst_b", {b_wen, b_done, b_err, b_busy, b_adr, b_din}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
    endtask

    // Reference: a frame is MAGIC, length, len words lo-first, 8-bit sum of data bytes.
    task automatic add_frame(input int len, input bit bad);
        logic [7:0] sum, lo, hi;
        sum = 8'h00;
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'(len));
        tx_q.push_back(8'(len >> 8));
        for (int i = 0; i < len; i++) begin
            lo = 8'($urandom);
            hi = 8'($urandom);
            tx_q.push_back(lo);
            tx_q.push_back(hi);
            sum = sum + lo + hi;
            exp_a.push_back({16'(i), hi, lo});
            exp_b.push_back({16'(32'hFFFF + i), hi, lo});
        end
        tx_q.push_back(bad ? sum + 8'h01 : sum);
    endtask

    task automatic compare_writes();
        check("nwr_a", 32'(got_a.size()), 32'(exp_a.size()));
        check("nwr_b", 32'(got_b.size()), 32'(exp_b.size()));
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) check("wr_a", got_a[i], exp_a[i]);
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) check("wr_b", got_b[i], exp_b[i]);
    endtask

    initial begin
        vt[0] = '{1'b1, 8, '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14, 8'h00, 8'h00},
                  2, 16'h0001, 16'h5678, 1'b1, 1'b0};
        vt[1] = '{1'b1, 8, '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h15, 8'h00, 8'h00},
                  2, 16'h0001, 16'h5678, 1'b0, 1'b1};
        vt[2] = '{1'b0, 4, '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  0, 16'h0001, 16'h5678, 1'b1, 1'b0};
        vt[3] = '{1'b1, 8, '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB, 8'h78, 8'h00, 8'h00},
                  1, 16'h0000, 16'hABCD, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        do_reset();

        for (int v = 0; v < 4; v++) begin
            int base;
            if (vt[v].rst) do_reset();
            base = got_a.size();
            for (int j = 0; j < vt[v].n; j++) send_byte(vt[v].b[j], 0);
            repeat (3) @(negedge clk);
            check("vec_nwr", 32'(got_a.size() - base), 32'(vt[v].nwr));
            check("vec_adr", {16'h0, a_adr}, {16'h0, vt[v].adr_last});
            check("vec_din", {16'h0, a_din}, {16'h0, vt[v].din_last});
            check("vec_flags", {a_done, a_err, a_busy}, {vt[v].done, vt[v].err, 1'b0});
            $display("vec %0d: writes=%0d adr=%04h din=%04h done=%b err=%b",
                     v, got_a.size() - base, a_adr, a_din, a_done, a_err);
        end

        // Write timing and address wrap on the FFFF-based instance.
        do_reset();
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        check("wr1_pulse", {a_wen, a_adr, a_din}, {1'b1, 16'h0000, 16'h1234});
        check("wr1_wrap", {b_wen, b_adr}, {1'b1, 16'hFFFF});
        @(negedge clk);
        check("wr1_hold", {a_wen, a_adr, a_din}, {1'b0, 16'h0000, 16'h1234});
        send_byte(8'h78, 0); send_byte(8'h56, 0);
        check("wr2_pulse", {a_wen, a_adr, a_din}, {1'b1, 16'h0001, 16'h5678});
        check("wr2_wrap", {b_wen, b_adr}, {1'b1, 16'h0000});
        check("pre_csum", {a_busy, a_done}, {1'b1, 1'b0});
        send_byte(8'h14, 0);
        check("done_next", {a_done, a_err, a_busy}, {1'b1, 1'b0, 1'b0});
        $display("seq timing: done=%b", a_done);

        // Timeout exactly TO idle cycles after the last byte.
        do_reset();
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h34, 0);
        repeat (TO - 1) @(negedge clk);
        check("to_before", {a_busy, a_err}, {1'b1, 1'b0});
        @(negedge clk);
        check("to_after", {a_busy, a_err}, {1'b0, 1'b1});
        repeat (2) @(negedge clk);
        check("to_nowr", 32'(got_a.size()), 0);
        $display("seq timeout: err=%b", a_err);

        // Framing error in IDLE is ignored; during DAT_HI it aborts without a write.
        do_reset();
        rx_ferr = 1'b1;
        @(negedge clk);
        rx_ferr = 1'b0;
        @(negedge clk);
        check("ferr_idle", {a_busy, a_err}, 0);
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h34, 0);
        rx_ferr = 1'b1;
        send_byte(8'h12, 0);
        rx_ferr = 1'b0;
        check("ferr_err", {a_wen, a_err, a_busy}, {1'b0, 1'b1, 1'b0});
        repeat (2) @(negedge clk);
        check("ferr_nowr", 32'(got_a.size()), 0);
        $display("seq ferr: err=%b", a_err);

        // Asynchronous reset mid-frame, full retransmit, bytes after DONE ignored.
        do_reset();
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        #1 rst_n = 1'b0;
        #1 check("async_rst", {a_wen, a_done, a_err, a_busy, a_adr, a_din}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got_a.delete();
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h34, 0);
        send_byte(8'h12, 0); send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h14, 0);
        repeat (3) @(negedge clk);
        check("retx_done", {a_done, a_err}, {1'b1, 1'b0});
        check("retx_nwr", 32'(got_a.size()), 2);
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        repeat (3) @(negedge clk);
        check("post_done_nwr", 32'(got_a.size()), 2);
        check("post_done", {a_done, a_busy}, {1'b1, 1'b0});
        $display("seq reset/retransmit: done=%b writes=%0d", a_done, got_a.size());

        // Random frames with leading junk, random gaps and optional bad checksum.
        for (int it = 0; it < 20; it++) begin
            bit bad, recover;
            logic [7:0] junk;
            do_reset();
            repeat ($urandom_range(0, 3)) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h00;
                tx_q.push_back(junk);
            end
            bad = ($urandom_range(0, 3) == 0);
            add_frame($urandom_range(0, 5), bad);
            recover = bad && ($urandom_range(0, 1) == 1);
            if (recover) begin
                tx_q.push_back(8'h3C);
                add_frame($urandom_range(0, 4), 1'b0);
            end
            send_q(3);
            repeat (3) @(negedge clk);
            compare_writes();
            check("rnd_a", {a_done, a_err, a_busy}, {!bad || recover, bad && !recover, 1'b0});
            check("rnd_b", {b_done, b_err, b_busy}, {!bad || recover, bad && !recover, 1'b0});
            $display("rnd %0d: bad=%b recover=%b writes=%0d done=%b err=%b",
                     it, bad, recover, got_a.size(), a_done, a_err);
        end

        check("never_both", {31'h0, both_seen}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
